// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI initiator.
// Includes the CRC7 byte-step function used when SD_SPI_CRC7_EN is defined.
package sd_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } sd_spi_state_e;

  localparam logic [6:0]  CRC7_POLY   = 7'h09;
  localparam logic        MOSI_IDLE   = 1'b1;
  localparam logic        SS_IDLE     = 1'b1;
  // Divider for the 100-400 kHz card-identification phase at 25 MHz.
  localparam int unsigned SD_INIT_DIV = 62;

  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_spi_crc7.sv
// Registered byte-wise CRC7 (x^7+x^3+1) accumulator; only built when
// SD_SPI_CRC7_EN is defined. A clear coinciding with en restarts from zero.
module sd_spi_crc7
  import sd_spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (en) begin
      crc_d = crc7_byte(clr ? 7'h00 : crc_q, data);
    end else if (clr) begin
      crc_d = 7'h00;
    end else begin
      crc_d = crc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_spi_master.sv
// Byte-oriented SPI mode-0 initiator for the SD card path.
// Optional CRC7 of transmitted bytes is enabled by defining SD_SPI_CRC7_EN.
module sd_spi_master
  import sd_spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             start,
  input  logic [7:0]       tx_byte,
  input  logic             cs_req,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rx_byte,
`ifdef SD_SPI_CRC7_EN
  input  logic             crc_clr,
  output logic [6:0]       crc7,
`endif
  output logic             sd_sclk_,
  output logic             sd_mosi_,
  input  logic             sd_miso_,
  output logic             sd_ss_
);

  sd_spi_state_e    state_q, state_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [6:0]       tx_sh_q, tx_sh_d;   // bits still to send after the one on MOSI
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             ss_q, ss_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SD_SPI_CRC7_EN
  logic [7:0]       tx_lat_q, tx_lat_d;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    div_d     = div_q;
    bitcnt_d  = bitcnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_byte_d = rx_byte_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_d      = ss_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef SD_SPI_CRC7_EN
    tx_lat_d  = tx_lat_q;
`endif
    case (state_q)
      IDLE: begin
        ss_d = ~cs_req;
        if (start) begin
          tx_sh_d  = tx_byte[6:0];
          div_d    = div;
          phase_d  = div;
          bitcnt_d = 3'd7;
          mosi_d   = tx_byte[7];
          busy_d   = 1'b1;
          state_d  = LOW;
`ifdef SD_SPI_CRC7_EN
          tx_lat_d = tx_byte;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      LOW: begin
        if (phase_q == '0) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], sd_miso_};
          phase_d = div_q;
          state_d = HIGH;
        end else begin
          phase_d = phase_q - {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      HIGH: begin
        if (phase_q == '0) begin
          sclk_d  = 1'b0;
          phase_d = div_q;
          if (bitcnt_q != 3'd0) begin
            mosi_d   = tx_sh_q[6];
            tx_sh_d  = {tx_sh_q[5:0], 1'b0};
            bitcnt_d = bitcnt_q - 3'd1;
            state_d  = LOW;
          end else begin
            rx_byte_d = rx_sh_q;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            mosi_d    = MOSI_IDLE;
            state_d   = IDLE;
          end
        end else begin
          phase_d = phase_q - {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      div_q     <= '0;
      bitcnt_q  <= 3'd0;
      tx_sh_q   <= 7'h00;
      rx_sh_q   <= 8'h00;
      rx_byte_q <= 8'h00;
      sclk_q    <= 1'b0;
      mosi_q    <= MOSI_IDLE;
      ss_q      <= SS_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SD_SPI_CRC7_EN
      tx_lat_q  <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      div_q     <= div_d;
      bitcnt_q  <= bitcnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_byte_q <= rx_byte_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SD_SPI_CRC7_EN
      tx_lat_q  <= tx_lat_d;
`endif
    end
  end

`ifdef SD_SPI_CRC7_EN
  sd_spi_crc7 u_crc7 (
    .clk   (clk),
    .reset (reset),
    .clr   (crc_clr),
    .en    (done_q),
    .data  (tx_lat_q),
    .crc   (crc7)
  );
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_byte  = rx_byte_q;
  assign sd_sclk_ = sclk_q;
  assign sd_mosi_ = mosi_q;
  assign sd_ss_   = ss_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Self-checking bench for sd_spi_master with a behavioural SPI slave and
// reference model; CRC checks are compiled in when SD_SPI_CRC7_EN is defined.
module tb_sd_spi_master;

  logic       clk = 1'b0;
  logic       reset, start, cs_req;
  logic [7:0] div, tx_byte, rx_byte;
  logic       busy, done, sd_sclk_, sd_mosi_, sd_miso_, sd_ss_;
  logic       lb_mode, resp_bit;
`ifdef SD_SPI_CRC7_EN
  logic       crc_clr;
  logic [6:0] crc7;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign sd_miso_ = lb_mode ? sd_mosi_ : resp_bit;

  sd_spi_master #(.DIV_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .div      (div),
    .start    (start),
    .tx_byte  (tx_byte),
    .cs_req   (cs_req),
    .busy     (busy),
    .done     (done),
    .rx_byte  (rx_byte),
`ifdef SD_SPI_CRC7_EN
    .crc_clr  (crc_clr),
    .crc7     (crc7),
`endif
    .sd_sclk_ (sd_sclk_),
    .sd_mosi_ (sd_mosi_),
    .sd_miso_ (sd_miso_),
    .sd_ss_   (sd_ss_)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte transfer; returns at the sample point of the done cycle.
  task automatic run_byte(input logic [7:0] tx, input int dv, input logic [7:0] rsp,
                          input logic lb, input bit pre, input bit mid_start,
                          input bit cs_drop, input bit chain,
                          input logic [7:0] next_tx, input int next_dv);
    int         rises, highs, mosi_bad, ss_bad, c, lim;
    logic [7:0] mbits;
    logic       prev_s, prev_m;
    bit         got;
    lb_mode  = lb;
    resp_bit = rsp[7];
    if (!pre) begin
      tx_byte = tx;
      div     = dv[7:0];
      start   = 1'b1;
    end
    tick();
    start   = 1'b0;
    div     = 8'($urandom);
    tx_byte = 8'($urandom);
    chk("busy_c1", {31'd0, busy}, 32'd1);
    chk("done_pulse", {31'd0, done}, 32'd0);
    rises = 0; highs = 0; mosi_bad = 0; ss_bad = 0; mbits = 8'h00;
    prev_s = 1'b0; prev_m = sd_mosi_; got = 1'b0; c = 1;
    lim = 16 * (dv + 1) + 40;
    while (!got && c <= lim) begin
      if (sd_sclk_ && !prev_s) begin
        if (rises < 8) mbits[7 - rises] = sd_mosi_;
        rises++;
        resp_bit = (rises < 8) ? rsp[7 - rises] : 1'b1;
      end
      if (sd_sclk_) highs++;
      if (cs_drop && sd_ss_ !== 1'b0) ss_bad++;
      if (done) begin
        got = 1'b1;
      end else if (c > 1 && sd_mosi_ !== prev_m && !(prev_s && !sd_sclk_)) begin
        mosi_bad++;
      end
      if (c == 5 && mid_start) begin
        start   = 1'b1;
        tx_byte = ~tx;
      end
      if (c == 6 && mid_start) start = 1'b0;
      if (c == 5 && cs_drop) cs_req = 1'b0;
      prev_s = sd_sclk_;
      prev_m = sd_mosi_;
      if (!got) begin
        tick();
        c++;
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("done_cycle", c, 1 + 16 * (dv + 1));
    chk("sclk_rises", rises, 8);
    chk("sclk_high_cycles", highs, 8 * (dv + 1));
    chk("mosi_bits", {24'd0, mbits}, {24'd0, tx});
    chk("mosi_change_off_fall", mosi_bad, 0);
    chk("rx_byte", {24'd0, rx_byte}, {24'd0, (lb ? tx : rsp)});
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("mosi_idle_at_done", {31'd0, sd_mosi_}, 32'd1);
    chk("sclk_low_at_done", {31'd0, sd_sclk_}, 32'd0);
    if (cs_drop) chk("ss_held_low", ss_bad, 0);
    if (chain) begin
      start   = 1'b1;
      tx_byte = next_tx;
      div     = next_dv[7:0];
    end
  endtask

`ifdef SD_SPI_CRC7_EN
  // CRC7 reference: long division of the message bit stream by x^7+x^3+1.
  function automatic logic [6:0] crc_ref(input logic [7:0] msg[$]);
    int r;
    r = 0;
    foreach (msg[k]) begin
      for (int i = 7; i >= 0; i--) begin
        r = (r << 1) | ((msg[k] >> i) & 1);
        if (r & 32'h80) r = r ^ 32'h89;
      end
    end
    for (int i = 0; i < 7; i++) begin
      r = r << 1;
      if (r & 32'h80) r = r ^ 32'h89;
    end
    return r[6:0];
  endfunction

  task automatic send_seq(input logic [7:0] msg[$]);
    foreach (msg[k]) run_byte(msg[k], 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    tick();
  endtask

  task automatic pulse_clr();
    crc_clr = 1'b1;
    tick();
    crc_clr = 1'b0;
  endtask
`endif

  initial begin
    logic [7:0] t, r, nt;
    int         dv, ndv, dcount;
    reset = 1'b1; start = 1'b0; cs_req = 1'b0; div = 8'd0; tx_byte = 8'h00;
    lb_mode = 1'b0; resp_bit = 1'b1;
`ifdef SD_SPI_CRC7_EN
    crc_clr = 1'b0;
`endif
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_sclk", {31'd0, sd_sclk_}, 32'd0);
    chk("rst_mosi", {31'd0, sd_mosi_}, 32'd1);
    chk("rst_ss", {31'd0, sd_ss_}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rx", {24'd0, rx_byte}, 32'd0);
`ifdef SD_SPI_CRC7_EN
    chk("rst_crc", {25'd0, crc7}, 32'd0);
`endif
    tick();

    // Loopback A5 at div 0, then divider 3 with MISO held high.
    run_byte(8'hA5, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    tick();
    run_byte(8'h00, 3, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    tick();

    // Back-to-back chain: second byte starts in the done cycle.
    run_byte(8'h3C, 1, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 2);
    run_byte(8'hC3, 2, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    tick();

    // Mid-byte start is ignored, no further transfer follows.
    run_byte(8'h81, 1, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0);
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy || done) dcount++;
    end
    chk("no_extra_transfer", dcount, 0);

    // Chip-select change deferred until after done.
    cs_req = 1'b1;
    tick();
    tick();
    chk("ss_selected", {31'd0, sd_ss_}, 32'd0);
    run_byte(8'h12, 0, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
    chk("ss_in_done_cycle", {31'd0, sd_ss_}, 32'd0);
    tick();
    chk("ss_after_done", {31'd0, sd_ss_}, 32'd1);

    // Randomized transfers against the slave model.
    for (int n = 0; n < 12; n++) begin
      t  = 8'($urandom);
      r  = 8'($urandom);
      dv = $urandom_range(0, 4);
      run_byte(t, dv, r, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      if ($urandom_range(0, 1) == 1) tick();
    end
    nt  = 8'($urandom);
    ndv = $urandom_range(0, 3);
    run_byte(8'hE7, 0, 8'h18, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, nt, ndv);
    run_byte(nt, ndv, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    tick();

    // Reset at cycle 8 of a byte aborts it.
    cs_req  = 1'b1;
    tick();
    tx_byte = 8'hF0; div = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_sclk", {31'd0, sd_sclk_}, 32'd0);
    chk("abort_mosi", {31'd0, sd_mosi_}, 32'd1);
    chk("abort_ss", {31'd0, sd_ss_}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rx", {24'd0, rx_byte}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dcount++;
      tick();
    end
    chk("abort_no_done", dcount, 0);

`ifdef SD_SPI_CRC7_EN
    begin
      logic [7:0] m[$];
      pulse_clr();
      m = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
      send_seq(m);
      chk("crc_cmd0", {25'd0, crc7}, 32'h4A);
      pulse_clr();
      m = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA};
      send_seq(m);
      chk("crc_cmd8", {25'd0, crc7}, 32'h43);
      pulse_clr();
      m = {};
      for (int i = 0; i < 4; i++) m.push_back(8'($urandom));
      send_seq(m);
      chk("crc_random", {25'd0, crc7}, {25'd0, crc_ref(m)});
      t = 8'($urandom);
      run_byte(t, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
      crc_clr = 1'b1;
      tick();
      crc_clr = 1'b0;
      m = '{t};
      chk("crc_clr_with_done", {25'd0, crc7}, {25'd0, crc_ref(m)});
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
